// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Byte buffer and launch controller in front of the UART TX control FSM.
//   The host pushes bytes at any rate. They are held in a DEPTH-entry circular
//   FIFO. One byte at a time is handed to the TX FSM/serializer with a
//   one-cycle Data_Valid pulse. The next launch waits until that frame is done.
//
// Ports
//   clk              in   system clock, rising edge
//   reset            in   asynchronous, active-low
//   i_wr_en          in   push request, sampled each rising edge
//   i_wr_data        in   byte to push
//   o_full           out  count == DEPTH
//   o_empty          out  count == 0
//   o_level          out  current count
//   o_overflow       out  sticky: a push was dropped (set beats i_ovf_clr)
//   i_ovf_clr        in   clears o_overflow
//   i_tx_busy        in   busy from TX FSM
//   o_tx_data_valid  out  Data_Valid to TX FSM, one-cycle registered pulse
//   o_tx_p_data      out  byte for the serializer, held until the next launch
//   o_launch_err     out  sticky: busy not seen within BUSY_TMO cycles of a
//                         launch; cleared only by reset
//   o_state          out  debug view of the launch FSM
//                         (0 IDLE, 1 LAUNCH, 2 WAIT_BUSY, 3 WAIT_DONE)
//
// Handshake with the TX FSM: o_tx_data_valid is high for exactly one cycle.
// o_tx_p_data is valid in that cycle and stays stable afterwards. The TX FSM
// acknowledges by raising i_tx_busy for the length of the frame. The frame is
// complete when i_tx_busy falls. No new launch happens while i_tx_busy is high.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int BUSY_TMO   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_wr_en,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH):0]       o_level,
  output logic                         o_overflow,
  input  logic                         i_ovf_clr,
  input  logic                         i_tx_busy,
  output logic                         o_tx_data_valid,
  output logic [DATA_WIDTH-1:0]        o_tx_p_data,
  output logic                         o_launch_err,
  output logic [1:0]                   o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_tx_valid;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_launch_err;
  logic [TW-1:0]         r_tmo;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_tmo_hit;

  assign w_full  = (r_count == LW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A launch pops the head. It happens only from IDLE with data available and
  // no frame in flight. A busy seen in IDLE means an external frame, so hold.
  assign w_pop  = (r_state == S_IDLE) && !w_empty && !i_tx_busy;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push = i_wr_en && (!w_full || w_pop);
  assign w_drop = i_wr_en && !w_push;

  // Next-state logic for the launch FSM
  always_comb begin
    w_next    = r_state;
    w_tmo_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_next = S_WAIT_DONE;
        end else if (r_tmo == TW'(BUSY_TMO - 1)) begin
          // BUSY_TMO cycles in WAIT_BUSY without an acknowledge
          w_tmo_hit = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Storage array: no reset, its contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The launch output register, the timeout timer and the sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_overflow   <= 1'b0;
      r_launch_err <= 1'b0;
      r_tmo        <= '0;
    end else begin
      // The valid register is high exactly while the FSM is in LAUNCH
      r_tx_valid <= (w_next == S_LAUNCH);
      if (w_pop) r_tx_data <= r_mem[r_rd_ptr];

      if (w_drop)         r_overflow <= 1'b1;
      else if (i_ovf_clr) r_overflow <= 1'b0;

      if (w_tmo_hit) r_launch_err <= 1'b1;

      // Count cycles spent waiting for busy. Restart whenever WAIT_BUSY is left.
      if ((r_state == S_WAIT_BUSY) && (w_next == S_WAIT_BUSY))
        r_tmo <= r_tmo + TW'(1);
      else
        r_tmo <= '0;
    end
  end

  assign o_full          = w_full;
  assign o_empty         = w_empty;
  assign o_level         = r_count;
  assign o_overflow      = r_overflow;
  assign o_tx_data_valid = r_tx_valid;
  assign o_tx_p_data     = r_tx_data;
  assign o_launch_err    = r_launch_err;
  assign o_state         = r_state;

endmodule
